fanout_branch_demux: RTL and testbench

Downstream stage of the FanOut link element: consumes the single forward-token stream and path grant produced by the FanOut controller and steers each message onto one or both of two output links. Each output has a 2-entry skid buffer, so a stall on one branch never corrupts the other. Back-prop tokens from both branches are merged into a single stall/terminate indication toward the FanOut controller.

---
 rtl/pkg_link.sv | 28 ++
 rtl/fanout_branch_skid.sv | 73 +++++++
 rtl/fanout_branch_demux.sv | 122 ++++++++++++
 tb/tb_fanout_branch_demux.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkg_link.sv
// Shared link-level types for the FanOut element: forward/back-prop tokens,
// the branch demux state encoding and the branch skid depth.
// No logic; types and constants only.
package pkg_link;

  // Forward token: valid, message-open marker, message-close marker, payload.
  typedef struct packed {
    logic        v;
    logic        a;
    logic        r;
    logic [31:0] d;
  } FTk_t;

  // Back-prop token: n = stall (not ready), t = terminate request.
  typedef struct packed {
    logic n;
    logic t;
  } BTk_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUTE = 2'd1,
    DROP  = 2'd2
  } branch_state_t;

  localparam int DEPTH_BRANCH_SKID = 2;

endpackage

// File: rtl/fanout_branch_skid.sv
// Purpose: 2-entry skid buffer for one FanOut output branch, registered head.
// Latency: a push at edge N is visible on head_o during cycle N+1 (if buffer was empty).
// Backpressure: pops when head valid and stall_i low; full_o tells the producer to hold off.
module fanout_branch_skid
  import pkg_link::*;
(
  input  logic clock_i,
  input  logic reset_ni,
  input  logic push_i,
  input  FTk_t push_dat_i,
  input  logic stall_i,
  output FTk_t head_o,
  output logic full_o
);

  localparam int CntW = $clog2(DEPTH_BRANCH_SKID + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH_BRANCH_SKID);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  FTk_t            head_q, head_d;
  FTk_t            tail_q, tail_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            pop;

  // Head is always either the oldest token or all-zero, so head_o.v doubles
  // as the "occupancy != 0" flag without extra muxing on the output.
  assign pop    = (cnt_q != '0) && !stall_i;
  assign full_o = (cnt_q == CntFull);
  assign head_o = head_q;

  // Next-state for head/tail/count from the push/pop combination.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    case ({push_i, pop})
      2'b10: begin
        if (cnt_q == '0) head_d = push_dat_i;
        else             tail_d = push_dat_i;
        cnt_d = cnt_q + CntOne;
      end
      2'b01: begin
        head_d = (cnt_q == CntFull) ? tail_q : '0;
        tail_d = '0;
        cnt_d  = cnt_q - CntOne;
      end
      2'b11: begin
        // Simultaneous push and pop: occupancy unchanged, queue shifts.
        if (cnt_q == CntFull) begin
          head_d = tail_q;
          tail_d = push_dat_i;
        end else begin
          head_d = push_dat_i;
        end
      end
      default: ;
    endcase
  end

  // Buffer storage with synchronous active-low clear.
  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/fanout_branch_demux.sv
// Purpose: steer FanOut messages to branch 0, branch 1 or both (FANOUT_BRANCH_BCAST_EN), or drop them.
// Latency: one cycle from accepted input token to O_FTk0/O_FTk1; O_Drop one cycle after a dropped open.
// Backpressure: O_BTk.n is combinational from selected skid fullness; no same-cycle path from I_BTkX.n.
module fanout_branch_demux
  import pkg_link::*;
#(
  parameter int WIDTH_DATA = 32,
  parameter int ExtdConfig = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  FTk_t                  I_FTk,
  output BTk_t                  O_BTk,
  input  logic [WIDTH_DATA-1:0] I_Grt,
  output FTk_t                  O_FTk0,
  output FTk_t                  O_FTk1,
  input  BTk_t                  I_BTk0,
  input  BTk_t                  I_BTk1,
  output logic                  O_Drop
);

  branch_state_t state_q, state_d;
  logic [1:0]    sel_q, sel_d;
  logic          drop_q, drop_d;

  logic [1:0] grt_sel;
  logic [1:0] sel_cur;
  logic       full0, full1;
  logic       push0, push1;
  logic       bp_n;
  logic       accept;
  logic       unused_cfg;

  // Only the two low grant bits and none of ExtdConfig carry meaning here.
  assign unused_cfg = (^I_Grt[WIDTH_DATA-1:2]) ^ (ExtdConfig != 0);

`ifdef FANOUT_BRANCH_BCAST_EN
  assign grt_sel = I_Grt[1:0];
`else
  // Without broadcast, a both-paths grant folds onto path 0.
  assign grt_sel = (I_Grt[1:0] == 2'b11) ? 2'b01 : I_Grt[1:0];
`endif

  // In IDLE the live grant decides which skids gate acceptance; afterwards the latched Sel.
  assign sel_cur = (state_q == IDLE) ? grt_sel : sel_q;
  assign bp_n    = (state_q != DROP) && ((sel_cur[0] && full0) || (sel_cur[1] && full1));
  assign accept  = I_FTk.v && !bp_n;

  assign O_BTk.n = bp_n;
  assign O_BTk.t = (state_q == ROUTE) && ((sel_q[0] && I_BTk0.t) || (sel_q[1] && I_BTk1.t));
  assign O_Drop  = drop_q;

  // Message FSM: decide routing at open, push into selected skids, return on close.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    drop_d  = 1'b0;
    push0   = 1'b0;
    push1   = 1'b0;
    case (state_q)
      IDLE: begin
        // Tokens without the open marker arriving in IDLE are consumed silently.
        if (accept && I_FTk.a) begin
          sel_d = grt_sel;
          if (grt_sel == 2'b00) begin
            drop_d = 1'b1;
            if (!I_FTk.r) state_d = DROP;
          end else begin
            push0 = grt_sel[0];
            push1 = grt_sel[1];
            if (!I_FTk.r) state_d = ROUTE;
          end
        end
      end
      ROUTE: begin
        if (accept) begin
          push0 = sel_q[0];
          push1 = sel_q[1];
          if (I_FTk.r) state_d = IDLE;
        end
      end
      DROP: begin
        if (accept && I_FTk.r) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, latched selection and drop pulse registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      sel_q   <= 2'b00;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      drop_q  <= drop_d;
    end
  end

  fanout_branch_skid u_skid0 (
    .clock_i    (clock),
    .reset_ni   (reset),
    .push_i     (push0),
    .push_dat_i (I_FTk),
    .stall_i    (I_BTk0.n),
    .head_o     (O_FTk0),
    .full_o     (full0)
  );

  fanout_branch_skid u_skid1 (
    .clock_i    (clock),
    .reset_ni   (reset),
    .push_i     (push1),
    .push_dat_i (I_FTk),
    .stall_i    (I_BTk1.n),
    .head_o     (O_FTk1),
    .full_o     (full1)
  );

endmodule

// File: tb/tb_fanout_branch_demux.sv
// Directed bench for fanout_branch_demux: routing, grant latching, stall, drop, reset.
// Broadcast behaviour is exercised when FANOUT_BRANCH_BCAST_EN is defined, path-0 folding otherwise.
// Outputs sampled 1 time unit after the rising edge; inputs driven right after.
module tb_fanout_branch_demux;
  import pkg_link::*;

  logic        clock = 1'b0;
  logic        reset;
  FTk_t        I_FTk;
  BTk_t        O_BTk;
  logic [31:0] I_Grt;
  FTk_t        O_FTk0;
  FTk_t        O_FTk1;
  BTk_t        I_BTk0;
  BTk_t        I_BTk1;
  logic        O_Drop;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  fanout_branch_demux #(.WIDTH_DATA(32), .ExtdConfig(0)) dut (
    .clock  (clock),
    .reset  (reset),
    .I_FTk  (I_FTk),
    .O_BTk  (O_BTk),
    .I_Grt  (I_Grt),
    .O_FTk0 (O_FTk0),
    .O_FTk1 (O_FTk1),
    .I_BTk0 (I_BTk0),
    .I_BTk1 (I_BTk1),
    .O_Drop (O_Drop)
  );

  function automatic FTk_t tok(input logic v, input logic a, input logic r, input logic [31:0] d);
    FTk_t t;
    t.v = v; t.a = a; t.r = r; t.d = d;
    return t;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_tok(input string name, input FTk_t obs, input FTk_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", name, obs, exp);
    end
  endtask

  FTk_t m[5];
  FTk_t zero_tok;

  initial begin
    zero_tok = '0;
    reset  = 1'b0;
    I_FTk  = '0;
    I_Grt  = '0;
    I_BTk0 = '0;
    I_BTk1 = '0;
    tick();
    tick();
    // Reset state
    check_tok("rst_out0", O_FTk0, zero_tok);
    check_tok("rst_out1", O_FTk1, zero_tok);
    check_bit("rst_bp_n", O_BTk.n, 1'b0);
    check_bit("rst_bp_t", O_BTk.t, 1'b0);
    check_bit("rst_drop", O_Drop, 1'b0);
    reset = 1'b1;
    tick();

    // Terminate requests are masked while IDLE
    I_BTk0.t = 1'b1; I_BTk1.t = 1'b1; #1;
    check_bit("idle_t_mask", O_BTk.t, 1'b0);
    I_BTk0.t = 1'b0; I_BTk1.t = 1'b0;

    // 1) Grant 1, 4-token message, no stalls
    m[0] = tok(1, 1, 0, 32'hA000_0001);
    m[1] = tok(1, 0, 0, 32'hA000_0002);
    m[2] = tok(1, 0, 0, 32'hA000_0003);
    m[3] = tok(1, 0, 1, 32'hA000_0004);
    I_Grt = 32'd1;
    for (int i = 0; i < 4; i++) begin
      I_FTk = m[i]; #1;
      check_bit("t1_bp_n", O_BTk.n, 1'b0);
      tick();
      check_tok("t1_out0", O_FTk0, m[i]);
      check_bit("t1_out1_v", O_FTk1.v, 1'b0);
      check_bit("t1_drop", O_Drop, 1'b0);
    end
    I_FTk = '0;
    tick();
    check_bit("t1_drain0", O_FTk0.v, 1'b0);

    // 2) Grant 2 at open, changed to 1 mid-message: all on branch 1
    m[0] = tok(1, 1, 0, 32'hB000_0001);
    m[1] = tok(1, 0, 0, 32'hB000_0002);
    m[2] = tok(1, 0, 1, 32'hB000_0003);
    I_Grt = 32'd2;
    I_FTk = m[0];
    tick();
    check_tok("t2_out1_a", O_FTk1, m[0]);
    check_bit("t2_out0_v_a", O_FTk0.v, 1'b0);
    I_Grt = 32'd1;
    I_BTk0.t = 1'b1; #1;
    check_bit("t2_t_unsel", O_BTk.t, 1'b0);
    I_BTk0.t = 1'b0; I_BTk1.t = 1'b1; #1;
    check_bit("t2_t_sel", O_BTk.t, 1'b1);
    I_BTk1.t = 1'b0;
    for (int i = 1; i < 3; i++) begin
      I_FTk = m[i];
      tick();
      check_tok("t2_out1", O_FTk1, m[i]);
      check_bit("t2_out0_v", O_FTk0.v, 1'b0);
    end
    I_FTk = '0;
    tick();
    check_bit("t2_drain1", O_FTk1.v, 1'b0);

    // 3) Grant 3 with a 3-cycle stall
    m[0] = tok(1, 1, 0, 32'hC000_0001);
    m[1] = tok(1, 0, 0, 32'hC000_0002);
    m[2] = tok(1, 0, 1, 32'hC000_0003);
    I_Grt = 32'd3;
`ifdef FANOUT_BRANCH_BCAST_EN
    I_FTk = m[0]; #1;
    check_bit("t3b_bp_open", O_BTk.n, 1'b0);
    tick();
    check_tok("t3b_e1_o0", O_FTk0, m[0]);
    check_tok("t3b_e1_o1", O_FTk1, m[0]);
    I_BTk1.n = 1'b1;
    I_FTk = m[1]; #1;
    check_bit("t3b_bp_e1", O_BTk.n, 1'b0);
    tick();
    check_tok("t3b_e2_o0", O_FTk0, m[1]);
    check_tok("t3b_e2_o1", O_FTk1, m[0]);
    I_FTk = m[2]; #1;
    check_bit("t3b_bp_full", O_BTk.n, 1'b1);
    tick();
    check_bit("t3b_e3_o0v", O_FTk0.v, 1'b0);
    check_tok("t3b_e3_o1", O_FTk1, m[0]);
    check_bit("t3b_bp_e3", O_BTk.n, 1'b1);
    tick();
    check_tok("t3b_e4_o1", O_FTk1, m[0]);
    I_BTk1.n = 1'b0; #1;
    check_bit("t3b_bubble", O_BTk.n, 1'b1);
    tick();
    check_bit("t3b_e5_o0v", O_FTk0.v, 1'b0);
    check_tok("t3b_e5_o1", O_FTk1, m[1]);
    check_bit("t3b_bp_e5", O_BTk.n, 1'b0);
    tick();
    check_tok("t3b_e6_o0", O_FTk0, m[2]);
    check_tok("t3b_e6_o1", O_FTk1, m[2]);
    I_FTk = '0;
    tick();
    check_bit("t3b_drain0", O_FTk0.v, 1'b0);
    check_bit("t3b_drain1", O_FTk1.v, 1'b0);
`else
    // Grant 3 folds onto path 0; branch 1 stall must be irrelevant.
    I_BTk1.n = 1'b1;
    I_FTk = m[0]; #1;
    check_bit("t3_bp_open", O_BTk.n, 1'b0);
    tick();
    check_tok("t3_e1_o0", O_FTk0, m[0]);
    check_bit("t3_e1_o1v", O_FTk1.v, 1'b0);
    I_BTk0.n = 1'b1;
    I_FTk = m[1]; #1;
    check_bit("t3_bp_e1", O_BTk.n, 1'b0);
    tick();
    check_tok("t3_e2_o0", O_FTk0, m[0]);
    I_FTk = m[2]; #1;
    check_bit("t3_bp_full", O_BTk.n, 1'b1);
    tick();
    check_tok("t3_e3_o0", O_FTk0, m[0]);
    check_bit("t3_bp_e3", O_BTk.n, 1'b1);
    tick();
    check_tok("t3_e4_o0", O_FTk0, m[0]);
    I_BTk0.n = 1'b0; #1;
    check_bit("t3_bubble", O_BTk.n, 1'b1);
    tick();
    check_tok("t3_e5_o0", O_FTk0, m[1]);
    check_bit("t3_bp_e5", O_BTk.n, 1'b0);
    tick();
    check_tok("t3_e6_o0", O_FTk0, m[2]);
    check_bit("t3_e6_o1v", O_FTk1.v, 1'b0);
    I_FTk = '0;
    tick();
    check_bit("t3_drain0", O_FTk0.v, 1'b0);
    I_BTk1.n = 1'b0;
`endif

    // 4) Grant 0: message dropped, then normal routing resumes
    m[0] = tok(1, 1, 0, 32'hD000_0001);
    m[1] = tok(1, 0, 0, 32'hD000_0002);
    m[2] = tok(1, 0, 1, 32'hD000_0003);
    I_Grt = 32'd0;
    I_FTk = m[0]; #1;
    check_bit("t4_bp_open", O_BTk.n, 1'b0);
    tick();
    check_bit("t4_drop_pulse", O_Drop, 1'b1);
    check_bit("t4_o0v_a", O_FTk0.v, 1'b0);
    check_bit("t4_o1v_a", O_FTk1.v, 1'b0);
    I_Grt = 32'd1;
    I_FTk = m[1]; #1;
    check_bit("t4_bp_drop", O_BTk.n, 1'b0);
    tick();
    check_bit("t4_drop_once", O_Drop, 1'b0);
    check_bit("t4_o0v_b", O_FTk0.v, 1'b0);
    I_FTk = m[2];
    tick();
    check_bit("t4_o0v_c", O_FTk0.v, 1'b0);
    check_bit("t4_drop_c", O_Drop, 1'b0);
    // Single-token message on path 0, then a 2-token message on path 1 back-to-back
    m[3] = tok(1, 1, 1, 32'hD100_0001);
    I_FTk = m[3];
    tick();
    check_tok("t4_single_o0", O_FTk0, m[3]);
    check_bit("t4_single_drop", O_Drop, 1'b0);
    m[0] = tok(1, 1, 0, 32'hD200_0001);
    m[1] = tok(1, 0, 1, 32'hD200_0002);
    I_Grt = 32'd2;
    I_FTk = m[0];
    tick();
    check_bit("t4_b2b_o0v", O_FTk0.v, 1'b0);
    check_tok("t4_b2b_o1a", O_FTk1, m[0]);
    I_FTk = m[1];
    tick();
    check_tok("t4_b2b_o1b", O_FTk1, m[1]);
    I_FTk = '0;
    tick();
    check_bit("t4_drain1", O_FTk1.v, 1'b0);

    // 5) Reset during the 2nd token of a 5-token message
    m[0] = tok(1, 1, 0, 32'hE000_0001);
    m[1] = tok(1, 0, 0, 32'hE000_0002);
    I_Grt = 32'd1;
    I_FTk = m[0];
    tick();
    check_tok("t5_pre_o0", O_FTk0, m[0]);
    I_FTk = m[1];
    reset = 1'b0;
    tick();
    check_tok("t5_rst_o0", O_FTk0, zero_tok);
    check_tok("t5_rst_o1", O_FTk1, zero_tok);
    check_bit("t5_rst_bp_n", O_BTk.n, 1'b0);
    check_bit("t5_rst_bp_t", O_BTk.t, 1'b0);
    check_bit("t5_rst_drop", O_Drop, 1'b0);
    reset = 1'b1;
    // A non-opening token must be discarded if the FSM is back in IDLE
    I_FTk = tok(1, 0, 0, 32'hE000_0003);
    tick();
    check_bit("t5_idle_o0v", O_FTk0.v, 1'b0);
    m[0] = tok(1, 1, 0, 32'hE100_0001);
    m[1] = tok(1, 0, 1, 32'hE100_0002);
    I_Grt = 32'd2;
    I_FTk = m[0];
    tick();
    check_tok("t5_fresh_a", O_FTk1, m[0]);
    I_FTk = m[1];
    tick();
    check_tok("t5_fresh_b", O_FTk1, m[1]);
    check_bit("t5_fresh_o0v", O_FTk0.v, 1'b0);
    I_FTk = '0;
    tick();
    check_bit("t5_drain1", O_FTk1.v, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
